// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch-side PC logic: icodes, default
// address width and conditional-jump prediction mode encodings.
package y86_pkg;

  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  localparam int ADDR_W_DEF = 64;

  localparam int PRED_ALWAYS_TAKEN = 0;
  localparam int PRED_BTFNT        = 1;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push on full overwrites the oldest entry,
// pop on empty is ignored and the top reads as zero while empty.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q addresses the next free slot; the top entry sits just below it
  assign top_idx = ptr_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC select/predict unit for the pipelined Y86-64 core.
// Define RAS_EN to add a return-address stack that predicts ret targets.
import y86_pkg::*;

module pc_predict_unit #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PRED_MODE = PRED_ALWAYS_TAKEN,
  parameter int                RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic              m_pred_taken,
  input  logic [ADDR_W-1:0] m_valC,
  input  logic [ADDR_W-1:0] m_valP,
  input  logic [3:0]        w_icode,
  input  logic [ADDR_W-1:0] w_valM,
  input  logic [ADDR_W-1:0] w_ras_pred,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_pred_taken,
  output logic [ADDR_W-1:0] f_ras_pred,
  output logic              redirect,
  output logic              ras_empty
);

  logic [ADDR_W-1:0] pred_q, pred_d;
  logic              mispredict;
  logic              ret_fix;
  logic [ADDR_W-1:0] m_target;

`ifdef RAS_EN
  logic ras_push;
  logic ras_pop;
  logic unused_ras_full;

  assign ras_push = !f_stall && (f_icode == ICODE_CALL);
  assign ras_pop  = !f_stall && (f_icode == ICODE_RET);

  // Not repaired on squash: a wrong prediction is caught by ret_fix in W
  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (f_valP),
    .top   (f_ras_pred),
    .empty (ras_empty),
    .full  (unused_ras_full)
  );

  assign ret_fix = (w_icode == ICODE_RET) && (w_valM != w_ras_pred);
`else
  logic unused_ras;

  assign unused_ras = ^{w_ras_pred, 32'(RAS_DEPTH)};
  assign f_ras_pred = '0;
  assign ras_empty  = 1'b1;
  assign ret_fix    = (w_icode == ICODE_RET);
`endif

  assign mispredict = (m_icode == ICODE_JXX) && (m_cnd != m_pred_taken);
  assign m_target   = m_cnd ? m_valC : m_valP;
  assign redirect   = mispredict | ret_fix;

  // Mispredict correction outranks a ret fix when both are in flight
  always_comb begin
    f_pc = pred_q;
    if (mispredict)   f_pc = m_target;
    else if (ret_fix) f_pc = w_valM;
  end

  always_comb begin
    f_pred_taken = 1'b0;
    if (f_icode == ICODE_JXX) begin
      if (PRED_MODE == PRED_BTFNT) f_pred_taken = (f_valC < f_valP);
      else                         f_pred_taken = 1'b1;
    end
  end

  always_comb begin
    pred_d = f_valP;
    case (f_icode)
      ICODE_CALL: pred_d = f_valC;
      ICODE_JXX:  pred_d = f_pred_taken ? f_valC : f_valP;
`ifdef RAS_EN
      ICODE_RET:  pred_d = f_ras_pred;
`endif
      default:    pred_d = f_valP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pred_q <= RESET_PC;
    else if (!f_stall) pred_q <= pred_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: two instances (always-taken and BTFNT) driven in
// parallel, directed scenarios followed by randomized traffic against a model.
module tb_pc_predict_unit;

  localparam logic [63:0] RST0 = 64'h0;
  localparam logic [63:0] RST1 = 64'h1000;
  localparam int DEPTH0 = 8;
  localparam int DEPTH1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic f_stall;
  logic [3:0] f_icode, m_icode, w_icode;
  logic [63:0] f_valC, f_valP, m_valC, m_valP, w_valM, w_ras_pred;
  logic m_cnd, m_pred_taken;

  logic [63:0] f_pc0, f_pc1, rp0, rp1;
  logic pt0, pt1, rd0, rd1, re0, re1;

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] pred_m [2];
  logic [63:0] ras_m0 [$];
  logic [63:0] ras_m1 [$];

  always #5 clk = ~clk;

  pc_predict_unit #(.ADDR_W(64), .RESET_PC(RST0), .PRED_MODE(0), .RAS_DEPTH(DEPTH0)) dut0 (
    .clk(clk), .rst(rst), .f_stall(f_stall), .f_icode(f_icode), .f_valC(f_valC),
    .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd), .m_pred_taken(m_pred_taken),
    .m_valC(m_valC), .m_valP(m_valP), .w_icode(w_icode), .w_valM(w_valM),
    .w_ras_pred(w_ras_pred), .f_pc(f_pc0), .f_pred_taken(pt0), .f_ras_pred(rp0),
    .redirect(rd0), .ras_empty(re0));

  pc_predict_unit #(.ADDR_W(64), .RESET_PC(RST1), .PRED_MODE(1), .RAS_DEPTH(DEPTH1)) dut1 (
    .clk(clk), .rst(rst), .f_stall(f_stall), .f_icode(f_icode), .f_valC(f_valC),
    .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd), .m_pred_taken(m_pred_taken),
    .m_valC(m_valC), .m_valP(m_valP), .w_icode(w_icode), .w_valM(w_valM),
    .w_ras_pred(w_ras_pred), .f_pc(f_pc1), .f_pred_taken(pt1), .f_ras_pred(rp1),
    .redirect(rd1), .ras_empty(re1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int ras_size(input int k);
    return (k == 0) ? ras_m0.size() : ras_m1.size();
  endfunction

  function automatic logic [63:0] ras_top(input int k);
`ifdef RAS_EN
    if (ras_size(k) == 0) return 64'h0;
    return (k == 0) ? ras_m0[ras_m0.size()-1] : ras_m1[ras_m1.size()-1];
`else
    return 64'h0;
`endif
  endfunction

  function automatic logic exp_empty(input int k);
`ifdef RAS_EN
    return ras_size(k) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_taken(input int k);
    if (f_icode != 4'd7) return 1'b0;
    if (k == 0) return 1'b1;
    return f_valC < f_valP;
  endfunction

  function automatic logic exp_redirect();
    logic mis, rfix;
    mis = (m_icode == 4'd7) && (m_cnd != m_pred_taken);
`ifdef RAS_EN
    rfix = (w_icode == 4'd9) && (w_valM != w_ras_pred);
`else
    rfix = (w_icode == 4'd9);
`endif
    return mis | rfix;
  endfunction

  function automatic logic [63:0] exp_fpc(input int k);
    if ((m_icode == 4'd7) && (m_cnd != m_pred_taken)) return m_cnd ? m_valC : m_valP;
    if (exp_redirect()) return w_valM;
    return pred_m[k];
  endfunction

  function automatic logic [63:0] exp_next(input int k);
    if (f_icode == 4'd8) return f_valC;
    if (f_icode == 4'd7) return exp_taken(k) ? f_valC : f_valP;
`ifdef RAS_EN
    if (f_icode == 4'd9) return ras_top(k);
`endif
    return f_valP;
  endfunction

  task automatic model_reset();
    pred_m[0] = RST0;
    pred_m[1] = RST1;
    ras_m0 = {};
    ras_m1 = {};
  endtask

  // Checks every output of both instances, clocks once, advances the model.
  task automatic step();
    logic [63:0] nxt [2];
    #1;
    chk("f_pc0", f_pc0, exp_fpc(0));
    chk("f_pc1", f_pc1, exp_fpc(1));
    chk("taken0", pt0, exp_taken(0));
    chk("taken1", pt1, exp_taken(1));
    chk("redirect0", rd0, exp_redirect());
    chk("redirect1", rd1, exp_redirect());
    chk("ras_pred0", rp0, ras_top(0));
    chk("ras_pred1", rp1, ras_top(1));
    chk("ras_empty0", re0, exp_empty(0));
    chk("ras_empty1", re1, exp_empty(1));
    nxt[0] = exp_next(0);
    nxt[1] = exp_next(1);
    @(posedge clk);
    if (!f_stall) begin
      pred_m[0] = nxt[0];
      pred_m[1] = nxt[1];
`ifdef RAS_EN
      if (f_icode == 4'd8) begin
        ras_m0.push_back(f_valP);
        if (ras_m0.size() > DEPTH0) void'(ras_m0.pop_front());
        ras_m1.push_back(f_valP);
        if (ras_m1.size() > DEPTH1) void'(ras_m1.pop_front());
      end else if (f_icode == 4'd9) begin
        if (ras_m0.size() > 0) void'(ras_m0.pop_back());
        if (ras_m1.size() > 0) void'(ras_m1.pop_back());
      end
`endif
    end
    #1;
  endtask

  task automatic quiet();
    f_stall = 1'b0; f_icode = 4'h1; m_icode = 4'h0; w_icode = 4'h0;
    m_cnd = 1'b0; m_pred_taken = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p);
    f_icode = ic; f_valC = c; f_valP = p;
  endtask

  initial begin
    logic [63:0] held;
    rst = 1'b1;
    quiet();
    f_valC = '0; f_valP = '0; m_valC = '0; m_valP = '0; w_valM = '0; w_ras_pred = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fpc0", f_pc0, RST0);
    chk("reset_fpc1", f_pc1, RST1);
    chk("reset_empty1", re1, 1'b1);
    rst = 1'b0;

    // Build pred_q = 0x40, then assert reset asynchronously mid-cycle
    fetch(4'h8, 64'h40, 64'h48); step();
    quiet();
    #1;
    chk("pre_reset_fpc0", f_pc0, 64'h40);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_fpc0", f_pc0, RST0);
    chk("async_reset_fpc1", f_pc1, RST1);
    chk("async_reset_empty0", re0, 1'b1);
    model_reset();
    #1 rst = 1'b0;

    // CALL redirects prediction to its destination
    fetch(4'h8, 64'h100, 64'h20); step();
    quiet();
    #1;
    chk("call_fpc0", f_pc0, 64'h100);
    chk("call_fpc1", f_pc1, 64'h100);
`ifdef RAS_EN
    chk("call_ras0", rp0, 64'h20);
`else
    chk("call_ras0", rp0, 64'h0);
`endif
    step();

    // Backward jump predicted taken under BTFNT, later found not taken
    fetch(4'h7, 64'h10, 64'h30);
    #1;
    chk("btfnt_taken", pt1, 1'b1);
    step();
    fetch(4'h7, 64'h90, 64'h30);
    #1;
    chk("btfnt_fwd_not_taken", pt1, 1'b0);
    chk("always_taken", pt0, 1'b1);
    step();
    quiet();
    m_icode = 4'h7; m_cnd = 1'b0; m_pred_taken = 1'b1; m_valC = 64'h10; m_valP = 64'h30;
    #1;
    chk("mispred_fpc1", f_pc1, 64'h30);
    chk("mispred_redirect1", rd1, 1'b1);
    step();

    // Mispredict and ret fix together; stall must hold pred_q regardless
    held = pred_m[1];
    f_stall = 1'b1; fetch(4'h8, 64'h777, 64'h999);
    m_icode = 4'h7; m_cnd = 1'b1; m_pred_taken = 1'b0; m_valC = 64'h50; m_valP = 64'h60;
    w_icode = 4'h9; w_valM = 64'h90; w_ras_pred = 64'h0;
    #1;
    chk("both_fpc0", f_pc0, 64'h50);
    chk("both_fpc1", f_pc1, 64'h50);
    step();
    quiet();
    #1;
    chk("stall_hold1", f_pc1, held);
    step();

`ifdef RAS_EN
    // Depth-2 stack: third push drops the oldest entry
    fetch(4'h8, 64'h200, 64'h8);  step();
    fetch(4'h8, 64'h300, 64'h10); step();
    fetch(4'h8, 64'h400, 64'h18); step();
    fetch(4'h9, 64'h0, 64'h401);
    #1; chk("ras_pop1", rp1, 64'h18); step();
    #1; chk("ras_pop2", rp1, 64'h10); step();
    #1; chk("ras_pop3", rp1, 64'h0);  step();
    quiet();
    w_icode = 4'h9; w_valM = 64'h8; w_ras_pred = 64'h0;
    #1;
    chk("ret_fix_redirect1", rd1, 1'b1);
    chk("ret_fix_fpc1", f_pc1, 64'h8);
    step();
    w_ras_pred = 64'h8;
    #1;
    chk("ret_ok_no_redirect", rd1, 1'b0);
    step();
`else
    quiet();
    w_icode = 4'h9; w_valM = 64'h8; w_ras_pred = 64'h8;
    #1;
    chk("ret_redirect0", rd0, 1'b1);
    chk("ret_fpc0", f_pc0, 64'h8);
    step();
`endif

    // Wrap-around addresses and unsigned compare at the top of the space
    quiet();
    fetch(4'h7, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_0002);
    #1; chk("wrap_fwd1", pt1, 1'b0); step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      f_stall = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 5);
      f_icode = (r < 2) ? 4'h7 : (r == 2) ? 4'h8 : (r == 3) ? 4'h9 : 4'($urandom_range(0, 15));
      f_valC = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      f_valP = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
      m_icode = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      m_cnd = 1'($urandom);
      m_pred_taken = 1'($urandom);
      m_valC = {$urandom, $urandom};
      m_valP = {$urandom, $urandom};
      w_icode = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      w_valM = 64'($urandom_range(0, 7));
      w_ras_pred = 64'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised fetch-side PC select/predict unit for the pipelined Y86-64 core; next generation of the single-cycle PC update.
- Holds the predicted-PC register, chooses the fetch PC each cycle from (mispredict correction, return target, prediction), and supports a selectable conditional-jump prediction mode.
- Optionally includes a return-address stack for predicting ret targets.
- Sits between fetch logic and the pipeline control unit; outputs a redirect flag used for squashing.

Parameters:
- ADDR_W, 64, PC/address width; all address ports use this width.
- RESET_PC, 0, value loaded into the predicted-PC register on reset.
- PRED_MODE, 0, 0 = always-taken; 1 = backward-taken/forward-not-taken (BTFNT).
- RAS_DEPTH, 8, return-stack entries, power of two, at least 2; unused without RAS_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- f_stall  in  1  hold the predicted-PC register and RAS.
- f_icode  in  4  icode of the instruction fetched at f_pc.
- f_valC  in  ADDR_W  constant or destination of the fetched instruction.
- f_valP  in  ADDR_W  fall-through address of the fetched instruction.
- m_icode  in  4  icode in the memory stage.
- m_cnd  in  1  resolved condition of the jump in the memory stage.
- m_pred_taken  in  1  prediction carried down with that jump.
- m_valC  in  ADDR_W  jump target carried to the memory stage.
- m_valP  in  ADDR_W  fall-through address carried to the memory stage.
- w_icode  in  4  icode in the write-back stage.
- w_valM  in  ADDR_W  actual return address popped by ret.
- w_ras_pred  in  ADDR_W  RAS prediction carried with the ret.
- f_pc  out  ADDR_W  fetch PC, combinational.
- f_pred_taken  out  1  jump prediction for the instruction at f_pc.
- f_ras_pred  out  ADDR_W  RAS top for a ret at f_pc.
- redirect  out  1  fetch redirected this cycle.
- ras_empty  out  1  RAS holds no valid entries.

Behaviour:
- Icodes: JXX=7, CALL=8, RET=9.
- Predicted-PC register pred_q: reset to RESET_PC.
  - On posedge, if !f_stall, pred_q <= next_pred.
  - If f_stall, pred_q holds; this applies even while redirect is high.
- mispredict = (m_icode==JXX) && (m_cnd != m_pred_taken). Correct target = m_cnd ? m_valC : m_valP.
- ret_fix:
  - Without RAS_EN: ret_fix = (w_icode==RET).
  - With RAS_EN: ret_fix = (w_icode==RET) && (w_valM != w_ras_pred).
- f_pc priority (combinational, zero latency):
  - mispredict selects the correct target;
  - otherwise ret_fix selects w_valM;
  - otherwise pred_q.
  - When both fire, mispredict wins.
- redirect = mispredict | ret_fix.
- f_pred_taken:
  - JXX with PRED_MODE 0: 1.
  - JXX with PRED_MODE 1: 1 iff f_valC < f_valP (unsigned), i.e. backward.
  - All other icodes: 0.
- next_pred:
  - CALL: f_valC.
  - JXX: f_valC if f_pred_taken, else f_valP.
  - RET with RAS_EN: RAS top.
  - Everything else, including RET without RAS_EN: f_valP. The control unit stalls fetch behind a ret.
- Address arithmetic is unsigned, ADDR_W bits, and wraps modulo 2^ADDR_W. No carries beyond ADDR_W.
- Reset:
  - Takes effect mid-operation: pred_q = RESET_PC, RAS pointer = 0, RAS count = 0.
  - Outputs follow combinationally, so f_pc = RESET_PC when no redirect is active.

Optional Feature:
- Macro RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular stack with top pointer and saturating count (0..RAS_DEPTH).
  - Push f_valP on an unstalled CALL fetch.
  - Pop on an unstalled RET fetch.
  - Push on full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop on empty returns 0; pointer and count are unchanged.
  - f_ras_pred = top entry, or 0 when empty.
  - RAS is not repaired on squash; ret_fix covers any mismatch.
- Undefined:
  - No stack storage.
  - f_ras_pred = 0 and ras_empty = 1 constantly.
  - w_ras_pred is ignored.

Decomposition:
- Shared package y86_pkg: icode constants (JXX, CALL, RET), ADDR_W default, PRED_MODE encodings.
- Sub-module ras_stack (params DEPTH, W; ports push, pop, din, top, empty, full), instantiated only under RAS_EN.

Test Plan:
- Reset is asserted async mid-cycle while pred_q=0x40 -> f_pc=RESET_PC immediately, ras_empty=1.
- CALL fetched with f_valC=0x100 and f_valP=0x20 -> next cycle f_pc=0x100; with RAS_EN, f_ras_pred=0x20.
- PRED_MODE=1, JXX with f_valC=0x10 and f_valP=0x30 -> f_pred_taken=1. A later m_cnd=0 with m_pred_taken=1 and m_valP=0x30 -> f_pc=0x30, redirect=1.
- Mispredict and W-stage RET in the same cycle (m target 0x50, w_valM 0x90) -> f_pc=0x50. With f_stall=1, pred_q holds.
- RAS_EN with RAS_DEPTH=2: three CALLs pushing 0x8, 0x10, 0x18, then three RETs -> predictions 0x18, 0x10, then 0. RET in W with w_valM=0x8 and w_ras_pred=0 -> redirect to 0x8.
